// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Time-shares one W-bit ALU among NREQ requesters. Each
//               transaction is accepted in IDLE, executed for one cycle, and
//               its result is returned on a one-hot valid/ready channel.
//               Optional macro ALU_ARB_FIXED_PRI_EN selects fixed priority
//               (requester 0 highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [2:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_flag,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_flag,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam logic [NREQ-1:0] c_ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [W-1:0]      r_alu_a;
    logic [W-1:0]      r_alu_b;
    logic [2:0]        r_alu_op;
    logic [W-1:0]      r_rsp_result;
    logic              r_rsp_flag;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic [7:0]        r_op_count;

    logic [1:0]        w_gnt;
    logic              w_found;
    logic              w_accept;
    logic              w_rsp_done;

`ifdef ALU_ARB_FIXED_PRI_EN
    // Descending scan so the lowest-indexed active requester is the last write.
    always_comb begin
        w_gnt   = 2'd0;
        w_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_gnt   = 2'(i);
                w_found = 1'b1;
            end
        end
    end
`else
    logic [1:0] r_ptr;

    // Scan offsets from the pointer downwards so the nearest offset wins.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = 2'd0;
        w_gnt   = r_ptr;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = r_ptr + 2'(k);
            if (req_valid[v_idx]) begin
                w_gnt   = v_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 2'd0;
        end else if (w_accept) begin
            r_ptr <= w_gnt + 2'd1;
        end
    end
`endif

    assign w_accept   = reset && (r_state == S_IDLE) && w_found;
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_grant];
    assign req_ready  = w_accept ? (c_ONE << w_gnt) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)    w_state_nxt = S_EXEC;
            S_EXEC:                  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // ALU operands change only on an accept, so they stay stable through EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_flag   <= 1'b0;
            r_rsp_valid  <= '0;
            r_grant      <= 2'd0;
            r_busy       <= 1'b0;
            r_op_count   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= req_a[w_gnt*W +: W];
                r_alu_b  <= req_b[w_gnt*W +: W];
                r_alu_op <= req_op[w_gnt*3 +: 3];
                r_grant  <= w_gnt;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_flag   <= alu_flag;
                r_rsp_valid  <= c_ONE << r_grant;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= '0;
                r_op_count  <= r_op_count + 8'd1;
            end
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flag   = r_rsp_flag;
    assign grant_id   = r_grant;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter with an adder ALU stub
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [27:0] req_a = '0;
    logic [27:0] req_b = '0;
    logic [11:0] req_op = '0;
    logic [6:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_flag;
    logic [3:0]  rsp_valid;
    logic [6:0]  rsp_result;
    logic        rsp_flag;
    logic [3:0]  rsp_ready = '0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  op_count;

    always #5 clk = ~clk;

    assign {alu_flag, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_share_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_ready  (rsp_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [6:0] res;
        logic       flag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   errors  = 0;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    function automatic exp_t model(input logic [1:0] id, input logic [6:0] a, input logic [6:0] b);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        return exp_t'{id, s[6:0], s[7]};
    endfunction

    task automatic set_req(input int i, input logic [6:0] a, input logic [6:0] b, input logic [2:0] op);
        req_a[i*7 +: 7] = a;
        req_b[i*7 +: 7] = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 7'(i + 9), 7'(i + 1), 3'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        vectors++;
        if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        vectors++;
        if (alu_a !== 7'd0) begin errors++; $display("FAIL reset_alu_a: got %0d want 0", alu_a); end
        vectors++;
        if ({busy, grant_id, rsp_result} !== 10'd0) begin
            errors++; $display("FAIL reset_busy_grant_rsp: got %b/%0d/%0d want 0/0/0", busy, grant_id, rsp_result);
        end
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single;
        apply_reset();
        set_req(2, 7'd5, 7'd3, 3'd0);
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_accept: got %b want 0100", req_ready); end
        sb.push_back(model(2'd2, 7'd5, 7'd3));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, busy, alu_a, alu_b, grant_id} !== {4'b0000, 1'b1, 7'd5, 7'd3, 2'd2}) begin
            errors++; $display("FAIL single_exec: got rv=%b busy=%b a=%0d b=%0d g=%0d want 0000/1/5/3/2",
                               rsp_valid, busy, alu_a, alu_b, grant_id);
        end
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if ({rsp_valid, rsp_result, rsp_flag} !== {oh(e.id), e.res, e.flag}) begin
            errors++; $display("FAIL single_rsp: got %b/%0d/%b want %b/%0d/%b",
                               rsp_valid, rsp_result, rsp_flag, oh(e.id), e.res, e.flag);
        end
        @(negedge clk);
        vectors++;
        if ({op_count, busy, rsp_valid} !== {8'd1, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL single_done: got cnt=%0d busy=%b rv=%b want 1/0/0000", op_count, busy, rsp_valid);
        end
    endtask

    task automatic test_overflow;
        apply_reset();
        set_req(0, 7'd100, 7'd50, 3'd1);
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL ovf_accept: got %b want 0001", req_ready); end
        sb.push_back(exp_t'{2'd0, 7'd22, 1'b1});
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if ({rsp_valid, rsp_result, rsp_flag, alu_op} !== {oh(e.id), e.res, e.flag, 3'd1}) begin
            errors++; $display("FAIL ovf_rsp: got %b/%0d/%b op=%0d want %b/%0d/%b op=1",
                               rsp_valid, rsp_result, rsp_flag, alu_op, oh(e.id), e.res, e.flag);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] g;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 7'(5 + 20 * i), 7'(40 + 25 * i), 3'(i));
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int n = 0; n < 5; n++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            g = 2'd0;
`else
            g = 2'(n);
`endif
            @(negedge clk);
            vectors++;
            if (req_ready !== oh(g)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, oh(g)); end
            sb.push_back(model(g, 7'(5 + 20 * g), 7'(40 + 25 * g)));
            repeat (2) @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({rsp_valid, rsp_result, rsp_flag} !== {oh(e.id), e.res, e.flag}) begin
                errors++; $display("FAIL rr_rsp%0d: got %b/%0d/%b want %b/%0d/%b",
                                   n, rsp_valid, rsp_result, rsp_flag, oh(e.id), e.res, e.flag);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        apply_reset();
        set_req(1, 7'd20, 7'd30, 3'd2);
        req_valid = 4'b0010;
        rsp_ready = 4'b0001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept: got %b want 0010", req_ready); end
        sb.push_back(model(2'd1, 7'd20, 7'd30));
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_result, req_ready} !== {4'b0010, 7'd50, 4'b0000}) begin
                errors++; $display("FAIL bp_hold%0d: got rv=%b res=%0d rr=%b want 0010/50/0000",
                                   k, rsp_valid, rsp_result, req_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 4'b0010;
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if ({rsp_valid, rsp_result, rsp_flag} !== {oh(e.id), e.res, e.flag}) begin
            errors++; $display("FAIL bp_rsp: got %b/%0d/%b want %b/%0d/%b",
                               rsp_valid, rsp_result, rsp_flag, oh(e.id), e.res, e.flag);
        end
        @(negedge clk);
        vectors++;
        if ({op_count, rsp_valid} !== {8'd1, 4'b0000}) begin
            errors++; $display("FAIL bp_done: got cnt=%0d rv=%b want 1/0000", op_count, rsp_valid);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midop;
        apply_reset();
        set_req(3, 7'd1, 7'd2, 3'd3);
        req_valid = 4'b1000;
        rsp_ready = 4'b1111;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_accept: got %b want 1000", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, busy, op_count, alu_a} !== 20'd0) begin
                errors++; $display("FAIL mid_discard%0d: got rv=%b busy=%b cnt=%0d a=%0d want all 0",
                                   k, rsp_valid, busy, op_count, alu_a);
            end
        end
    endtask

    task automatic test_wrap;
        int hs;
        bit seen255;
        hs = 0;
        seen255 = 1'b0;
        apply_reset();
        set_req(0, 7'd1, 7'd1, 3'd0);
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 2000 && hs < 256; k++) begin
            @(negedge clk);
            if (hs == 255 && !seen255) begin
                seen255 = 1'b1;
                vectors++;
                if (op_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", op_count); end
            end
            if (|(rsp_valid & rsp_ready)) hs++;
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if (hs != 256) begin errors++; $display("FAIL wrap_timeout: got %0d handshakes want 256", hs); end
        vectors++;
        if (op_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
